// File: rtl/traffic_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_activity_monitor
// Purpose  : Counts bit toggles, weighted switching energy and illegal
//            (non-one-hot) cycles on the four traffic-light buses. Publishes
//            one result per WINDOW sample cycles via a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module traffic_activity_monitor #(
   parameter int WINDOW = 256,
   parameter int CNT_W  = 16,
   parameter int ACC_W  = 24,
   parameter int W_R    = 4,
   parameter int W_Y    = 2,
   parameter int W_G    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       light_M1,
   input  logic [2:0]       light_S,
   input  logic [2:0]       light_M2,
   input  logic [2:0]       light_MT,
   output logic [CNT_W-1:0] win_toggles,
   output logic [ACC_W-1:0] win_energy,
   output logic [CNT_W-1:0] win_illegal,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             overrun
);

   localparam int              WC_W     = $clog2(WINDOW);
   localparam logic [WC_W-1:0] LAST_CNT = WC_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      ACCUM = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [11:0]      prev_q, prev_d;
   logic [CNT_W-1:0] tog_acc_q, tog_acc_d;
   logic [ACC_W-1:0] en_acc_q, en_acc_d;
   logic [CNT_W-1:0] ill_acc_q, ill_acc_d;
   logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] res_tog_q, res_tog_d;
   logic [ACC_W-1:0] res_en_q, res_en_d;
   logic [CNT_W-1:0] res_ill_q, res_ill_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   logic [11:0]      cur;
   logic [11:0]      diff;
   logic [2:0]       red_tog, yel_tog, grn_tog;
   logic             ill_now;
   logic [CNT_W-1:0] step_tog;
   logic [ACC_W-1:0] step_en;
   logic [CNT_W-1:0] sum_tog, sum_ill;
   logic [ACC_W-1:0] sum_en;

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[ACC_W] ? '1 : s[ACC_W-1:0];
   endfunction

   // Per-sample contribution: per-colour toggle counts and one-hot legality.
   always_comb begin
      logic [2:0] bus;
      cur     = {light_M1, light_S, light_M2, light_MT};
      diff    = prev_q ^ cur;
      red_tog = '0;
      yel_tog = '0;
      grn_tog = '0;
      ill_now = 1'b0;
      bus     = '0;
      for (int b = 0; b < 4; b++) begin
         bus     = cur[3*b +: 3];
         red_tog = red_tog + {2'b00, diff[3*b+2]};
         yel_tog = yel_tog + {2'b00, diff[3*b+1]};
         grn_tog = grn_tog + {2'b00, diff[3*b]};
         if (!((bus == 3'b100) || (bus == 3'b010) || (bus == 3'b001))) begin
            ill_now = 1'b1;
         end
      end
      step_tog = CNT_W'(int'(red_tog) + int'(yel_tog) + int'(grn_tog));
      step_en  = ACC_W'(W_R * int'(red_tog) + W_Y * int'(yel_tog) + W_G * int'(grn_tog));
      sum_tog  = sat_cnt(tog_acc_q, step_tog);
      sum_en   = sat_acc(en_acc_q, step_en);
      sum_ill  = sat_cnt(ill_acc_q, CNT_W'(ill_now));
   end

   // Next-state logic: FSM sequencing, accumulation, window close and handshake.
   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      tog_acc_d = tog_acc_q;
      en_acc_d  = en_acc_q;
      ill_acc_d = ill_acc_q;
      win_cnt_d = win_cnt_q;
      res_tog_d = res_tog_q;
      res_en_d  = res_en_q;
      res_ill_d = res_ill_q;
      overrun_d = overrun_q;
      // A pending result drops once accepted; a same-edge close re-asserts it.
      valid_d   = valid_q && !win_ready;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = PRIME;
            end
         end
         PRIME: begin
            prev_d  = cur;
            state_d = ACCUM;
         end
         ACCUM: begin
            if (!en) begin
               state_d = IDLE;
            end else begin
               prev_d = cur;
               if (win_cnt_q == LAST_CNT) begin
                  if (!valid_q || win_ready) begin
                     res_tog_d = sum_tog;
                     res_en_d  = sum_en;
                     res_ill_d = sum_ill;
                     valid_d   = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
                  tog_acc_d = '0;
                  en_acc_d  = '0;
                  ill_acc_d = '0;
                  win_cnt_d = '0;
               end else begin
                  tog_acc_d = sum_tog;
                  en_acc_d  = sum_en;
                  ill_acc_d = sum_ill;
                  win_cnt_d = win_cnt_q + WC_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         tog_acc_q <= '0;
         en_acc_q  <= '0;
         ill_acc_q <= '0;
         win_cnt_q <= '0;
         res_tog_q <= '0;
         res_en_q  <= '0;
         res_ill_q <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         tog_acc_q <= tog_acc_d;
         en_acc_q  <= en_acc_d;
         ill_acc_q <= ill_acc_d;
         win_cnt_q <= win_cnt_d;
         res_tog_q <= res_tog_d;
         res_en_q  <= res_en_d;
         res_ill_q <= res_ill_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign win_toggles = res_tog_q;
   assign win_energy  = res_en_q;
   assign win_illegal = res_ill_q;
   assign win_valid   = valid_q;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_activity_monitor
// Purpose  : Randomised and directed self-checking bench for
//            traffic_activity_monitor against a behavioural window model.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_activity_monitor;

   localparam int WINDOW = 8;
   localparam int CNT_W  = 16;
   localparam int ACC_W  = 24;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             win_ready = 1'b0;
   logic [2:0]       l_m1 = 3'b100, l_s = 3'b100, l_m2 = 3'b100, l_mt = 3'b100;
   logic [CNT_W-1:0] win_toggles;
   logic [ACC_W-1:0] win_energy;
   logic [CNT_W-1:0] win_illegal;
   logic             win_valid;
   logic             overrun;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // behavioural model state
   int          m_phase;   // 0 waiting for enable, 1 capture pending, 2 sampling
   logic [11:0] m_prev;
   int          m_tog, m_en, m_ill, m_cnt;
   int          e_tog, e_en, e_ill;
   bit          e_valid, e_ovr;

   traffic_activity_monitor #(
      .WINDOW(WINDOW), .CNT_W(CNT_W), .ACC_W(ACC_W), .W_R(4), .W_Y(2), .W_G(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .light_M1   (l_m1),
      .light_S    (l_s),
      .light_M2   (l_m2),
      .light_MT   (l_mt),
      .win_toggles(win_toggles),
      .win_energy (win_energy),
      .win_illegal(win_illegal),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int weight(input int k);
      if (k % 3 == 2) return 4;
      if (k % 3 == 1) return 2;
      return 1;
   endfunction

   function automatic logic [2:0] rand_light();
      logic [2:0] v;
      if ($urandom % 4 != 0) v = 3'(3'b001 << ($urandom % 3));
      else v = 3'($urandom % 8);
      return v;
   endfunction

   // Reference model: advances one clock edge using the window rules.
   always @(posedge clk) begin
      logic [11:0] cur;
      logic [2:0]  bus;
      int t, e, il;
      bit nv;
      cur = {l_m1, l_s, l_m2, l_mt};
      if (rst) begin
         m_phase = 0; m_prev = '0;
         m_tog = 0; m_en = 0; m_ill = 0; m_cnt = 0;
         e_tog = 0; e_en = 0; e_ill = 0; e_valid = 0; e_ovr = 0;
      end else begin
         nv = e_valid && !win_ready;
         if (m_phase == 0) begin
            if (en) m_phase = 1;
         end else if (m_phase == 1) begin
            m_prev  = cur;
            m_phase = 2;
         end else if (!en) begin
            m_phase = 0;
         end else begin
            t = 0; e = 0; il = 0;
            for (int k = 0; k < 12; k++) begin
               if (cur[k] != m_prev[k]) begin
                  t++;
                  e += weight(k);
               end
            end
            for (int b = 0; b < 4; b++) begin
               bus = cur[3*b +: 3];
               if (!(bus inside {3'b100, 3'b010, 3'b001})) il = 1;
            end
            m_tog = (m_tog + t > CNT_MAX) ? CNT_MAX : m_tog + t;
            m_en  = (m_en + e > ACC_MAX) ? ACC_MAX : m_en + e;
            m_ill = (m_ill + il > CNT_MAX) ? CNT_MAX : m_ill + il;
            m_prev = cur;
            m_cnt++;
            if (m_cnt == WINDOW) begin
               if (!e_valid || win_ready) begin
                  e_tog = m_tog; e_en = m_en; e_ill = m_ill;
                  nv = 1;
               end else begin
                  e_ovr = 1;
               end
               m_tog = 0; m_en = 0; m_ill = 0; m_cnt = 0;
            end
         end
         e_valid = nv;
      end
   end

   // Compare process: outputs are registered, so check them every cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         check("valid",    32'(win_valid),   32'(e_valid));
         check("overrun",  32'(overrun),     32'(e_ovr));
         check("toggles",  32'(win_toggles), e_tog);
         check("energy",   32'(win_energy),  e_en);
         check("illegal",  32'(win_illegal), e_ill);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic rand_lights();
      l_m1 = rand_light(); l_s = rand_light(); l_m2 = rand_light(); l_mt = rand_light();
   endtask

   task automatic static_lights();
      l_m1 = 3'b100; l_s = 3'b100; l_m2 = 3'b100; l_mt = 3'b100;
   endtask

   initial begin
      // reset with random lights
      rand_lights();
      rst = 1'b1;
      tick();
      chk_on = 1'b1;
      tick();
      check("rst_toggles", 32'(win_toggles), 0);
      check("rst_energy",  32'(win_energy),  0);
      check("rst_illegal", 32'(win_illegal), 0);
      check("rst_valid",   32'(win_valid),   0);
      check("rst_overrun", 32'(overrun),     0);
      rst = 1'b0;
      repeat (5) begin
         rand_lights();
         tick();
      end
      check("idle_valid", 32'(win_valid), 0);

      // static lights: one result at edge WINDOW+2, all zero
      do_reset();
      static_lights();
      win_ready = 1'b1;
      en = 1'b1;
      repeat (9) tick();
      check("static_early_valid", 32'(win_valid), 0);
      tick();
      check("static_valid",   32'(win_valid),   1);
      check("static_toggles", 32'(win_toggles), 0);
      check("static_energy",  32'(win_energy),  0);
      check("static_illegal", 32'(win_illegal), 0);
      tick();
      check("static_valid_drop", 32'(win_valid), 0);

      // alternating M1 100/010
      do_reset();
      static_lights();
      en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         l_m1 = (i % 2 == 1) ? 3'b010 : 3'b100;
         tick();
      end
      check("alt_valid",   32'(win_valid),   1);
      check("alt_toggles", 32'(win_toggles), 16);
      check("alt_energy",  32'(win_energy),  48);
      check("alt_illegal", 32'(win_illegal), 0);

      // illegal encodings on S: 000 x3 then 110
      do_reset();
      static_lights();
      en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i >= 4 && i <= 6) l_s = 3'b000;
         else if (i == 7)      l_s = 3'b110;
         else                  l_s = 3'b100;
         tick();
      end
      check("ill_valid",   32'(win_valid),   1);
      check("ill_toggles", 32'(win_toggles), 4);
      check("ill_energy",  32'(win_energy),  12);
      check("ill_illegal", 32'(win_illegal), 4);

      // backpressure across two closes, then ready on the third close
      do_reset();
      win_ready = 1'b0;
      en = 1'b1;
      repeat (18) begin
         rand_lights();
         tick();
      end
      check("bp_valid",   32'(win_valid), 1);
      check("bp_overrun", 32'(overrun),   1);
      repeat (7) begin
         rand_lights();
         tick();
      end
      win_ready = 1'b1;
      rand_lights();
      tick();
      check("bp_b2b_valid", 32'(win_valid), 1);
      tick();
      check("bp_drop_valid", 32'(win_valid), 0);
      check("bp_overrun_sticky", 32'(overrun), 1);

      // pause mid-window with M1 toggling in the gap
      do_reset();
      en = 1'b1;
      repeat (5) begin
         rand_lights();
         tick();
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         l_m1 = (i % 2 == 0) ? 3'b001 : 3'b010;
         tick();
      end
      en = 1'b1;
      repeat (20) begin
         rand_lights();
         tick();
      end

      // reset after 5 samples; next window needs a fresh PRIME + WINDOW samples
      do_reset();
      en = 1'b1;
      repeat (7) begin
         rand_lights();
         tick();
      end
      do_reset();
      en = 1'b1;
      repeat (9) begin
         rand_lights();
         tick();
      end
      check("rst_mid_early", 32'(win_valid), 0);
      rand_lights();
      tick();
      check("rst_mid_valid", 32'(win_valid), 1);

      // randomised traffic
      do_reset();
      repeat (1500) begin
         rst       = ($urandom % 300 == 0);
         en        = ($urandom % 10 != 0);
         win_ready = ($urandom % 3 != 0);
         rand_lights();
         tick();
      end
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_activity_monitor.md
# traffic_activity_monitor

Downstream consumer of the traffic light controller outputs (`light_M1`, `light_S`, `light_M2`, `light_MT`). It samples the four 3-bit light buses every enabled cycle and counts bit toggles. It accumulates a per-colour weighted switching-energy estimate and counts cycles with illegal (non-one-hot) light encodings. Results are published once per fixed-length window through a valid/ready handshake, feeding the power-estimation datapath.

## Interface
- `WINDOW`, 256: counted sample cycles per measurement window (≥2).
- `CNT_W`, 16: width of the toggle and illegal counters.
- `ACC_W`, 24: width of the energy accumulator.
- `W_R`, 4: energy weight per toggle on bit 2 (red).
- `W_Y`, 2: energy weight per toggle on bit 1 (yellow).
- `W_G`, 1: energy weight per toggle on bit 0 (green).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  sampling enable.
- `light_M1`, `light_S`, `light_M2`, `light_MT`  in  3 each  light buses, encoded {R,Y,G}.
- `win_toggles`  out  CNT_W  total toggled bits in the last published window.
- `win_energy`  out  ACC_W  weighted toggle sum for that window.
- `win_illegal`  out  CNT_W  cycles in that window with at least one bus not in {100,010,001}.
- `win_valid`  out  1  result registers hold an unconsumed window.
- `win_ready`  in  1  consumer accepts the result.
- `overrun`  out  1  sticky: a completed window was dropped.

## Operation
- FSM states: IDLE, PRIME, ACCUM. Reset puts the FSM in IDLE.
- IDLE with `en`=1 goes to PRIME. PRIME captures all 12 bits into `prev`, counts nothing, and goes to ACCUM.
- ACCUM with `en`=1 (a sample cycle) does the following each cycle:
  - t = popcount(prev ^ cur), range 0..12.
  - e = W_R·(red toggles) + W_Y·(yellow toggles) + W_G·(green toggles).
  - ill = 1 if any bus is not one-hot.
  - tog_acc += t, en_acc += e, ill_acc += ill.
  - prev ← cur; win_cnt += 1.
- ACCUM with `en`=0 goes to IDLE. Accumulators and `win_cnt` hold. On re-enable, PRIME runs again, so toggles across the gap are never counted.
- All accumulators saturate at all-ones. They never wrap.
- Window close happens on the sample cycle where win_cnt = WINDOW-1, with that cycle's contribution included:
  - If the result registers are free (win_valid=0, or win_valid=1 with win_ready=1 on this edge), load the final sums and set win_valid=1.
  - Otherwise keep the old result, set `overrun`=1 (cleared only by `rst`), and discard the new sums.
  - In either case, on the same edge, clear the accumulators and win_cnt to 0 and stay in ACCUM. There is no dead cycle.
- Handshake:
  - A transfer occurs on an edge where win_valid && win_ready.
  - win_valid falls after the transfer unless a window closes on that same edge; in that case win_valid stays 1 with new data and `overrun` is not set.
  - The outputs are stable while win_valid=1 and win_ready=0.

## Timing
- Reset values: win_toggles=0, win_energy=0, win_illegal=0, win_valid=0, overrun=0. Internally prev=0, all accumulators 0, win_cnt=0, state IDLE.
- `rst` mid-window discards all partial sums. The first window after release needs 1 PRIME cycle plus WINDOW sample cycles.
- Latency: win_valid is registered. It is visible in the cycle after the edge that clocks the last sample.
- From an idle start with `en` held high, the first win_valid=1 appears WINDOW+2 edges after `en` is sampled high (IDLE→PRIME, PRIME, then WINDOW samples).
- `en` is sampled every edge. Inputs are treated as synchronous to `clk`.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with random light inputs. All outputs must read 0; win_valid must stay 0 for 5 cycles with `en`=0.
- Static lights: WINDOW=8, all buses 3'b100, `en`=1, `win_ready`=1. Expect win_valid high for 1 cycle at edge 10 with toggles=0, energy=0, illegal=0.
- Alternating M1: light_M1 alternates 100/010 every cycle, other buses constant, WINDOW=8, weights 4/2/1. Expect toggles=16, energy=48, illegal=0.
- Illegal encoding: light_S=3'b000 for 3 sample cycles and 3'b110 for 1, all else legal and static. Expect illegal=4. Toggle count must reflect the transitions into and out of 000/110.
- Backpressure: win_ready=0 across 2 window closes. The first result is held unchanged and overrun=1. Raising win_ready on the cycle of a third close gives back-to-back valid with the third window's data.
- Pause and reset mid-run: drop `en` for 3 cycles mid-window while M1 toggles during the gap. Expect no gap toggles counted and a 1-cycle PRIME on resume. Asserting `rst` after 5 samples must make the next window count a fresh 8 samples.
